// File: rtl/rom_dl_pkg.sv
// rom_dl_pkg: shared types and index constants for the ioctl ROM/DIP download sequencer.
//   dl_state_t    : sequencer state (IDLE, LOAD, DRAIN, HOLD, RUN)
//   ROM_INDEX_DEF : default ioctl_index carrying ROM bytes
//   DSW_INDEX_DEF : default ioctl_index carrying DIP-switch bytes
package rom_dl_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} dl_state_t;
    localparam logic [7:0] ROM_INDEX_DEF = 8'd0;
    localparam logic [7:0] DSW_INDEX_DEF = 8'd254;
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO with a registered head.
//   clk_sys, reset_n : clock, async active-low reset (flushes contents, head=0)
//   push, din        : write request and data; accepted when not full or popping
//   pop              : consume head; ignored while empty
//   head             : registered show-ahead head entry
//   count, full, empty : occupancy status
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk_sys,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr, rd_nx;
    logic [WIDTH-1:0] head_n;
    logic             pop_ok, push_ok;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_nx   = rd_ptr + 1'b1;
    // Head is the entry behind the popped one, or the incoming byte when
    // the FIFO is (or becomes) empty at the moment of the push.
    always_comb begin
        head_n = pop_ok ? ((count == CW'(1)) ? (push_ok ? din : head) : mem[rd_nx])
                        : ((empty & push_ok) ? din : head);
    end
    always_ff @(posedge clk_sys) begin
        if (push_ok) mem[wr_ptr] <= din;
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= pop_ok ? rd_nx : rd_ptr;
            wr_ptr <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
            count  <= count + CW'(push_ok) - CW'(pop_ok);
            head   <= head_n;
        end
    end
endmodule

// File: rtl/rom_dl_sequencer.sv
// rom_dl_sequencer: routes the hps_io ioctl download stream to the ROM write port and DIP bank, owns core reset.
//   clk_sys, reset_n            : clock, async active-low reset
//   ioctl_download/wr/index/addr/dout : download stream from hps_io
//   ioctl_wait                  : registered back-pressure to the HPS
//   rom_addr, rom_data, rom_wr  : FIFO head toward the ROM target; consumed on rom_wr & rom_ready
//   rom_ready                   : ROM target accepts the head this cycle
//   dsw                         : eight captured DIP bytes
//   core_reset                  : active-high core reset, low only in RUN
//   rom_loaded, dl_error        : load-complete flag and sticky drop/range error
module rom_dl_sequencer
    import rom_dl_pkg::*;
#(
    parameter int         ADDR_W      = 17,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         HOLD_CYCLES = 16,
    parameter logic [7:0] ROM_INDEX   = ROM_INDEX_DEF,
    parameter logic [7:0] DSW_INDEX   = DSW_INDEX_DEF
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [7:0]        ioctl_index,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              ioctl_wait,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic              rom_wr,
    input  logic              rom_ready,
    output logic [63:0]       dsw,
    output logic              core_reset,
    output logic              rom_loaded,
    output logic              dl_error
);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    localparam int HW = $clog2(HOLD_CYCLES+1);
    dl_state_t         state, state_n;
    logic [HW-1:0]     cnt, cnt_n;
    logic [ADDR_W+7:0] head;
    logic [CW-1:0]     count, count_n;
    logic              full, empty, pop, push, push_ok, rom_start, rom_byte, in_range;
    assign rom_start  = ioctl_download & (ioctl_index == ROM_INDEX);
    assign rom_byte   = (state == LOAD) & ioctl_wr & (ioctl_index == ROM_INDEX);
    assign in_range   = (ioctl_addr >> ADDR_W) == 25'd0;
    assign push       = rom_byte & in_range;
    assign rom_wr     = ~empty;
    assign pop        = rom_wr & rom_ready;
    assign push_ok    = push & (~full | pop);
    assign count_n    = count + CW'(push_ok) - CW'(pop);
    assign core_reset = state != RUN;
    assign rom_addr   = head[ADDR_W+7:8];
    assign rom_data   = head[7:0];
    sync_fifo_fwft #(.WIDTH(ADDR_W+8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .push    (push),
        .din     ({ioctl_addr[ADDR_W-1:0], ioctl_dout}),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:  state_n = rom_start ? LOAD : IDLE;
            LOAD:  state_n = ioctl_download ? LOAD : DRAIN;
            DRAIN: begin
                state_n = rom_start ? LOAD : (empty ? HOLD : DRAIN);
                cnt_n   = HW'(HOLD_CYCLES-1);
            end
            HOLD: begin
                state_n = rom_start ? LOAD : ((cnt == '0) ? RUN : HOLD);
                cnt_n   = (cnt == '0) ? cnt : cnt - 1'b1;
            end
            RUN:     state_n = rom_start ? LOAD : RUN;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ioctl_wait <= 1'b0;
            rom_loaded <= 1'b0;
            dl_error   <= 1'b0;
            dsw        <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            // One slot of margin so a strobe already in flight still fits.
            ioctl_wait <= count_n >= CW'(FIFO_DEPTH-1);
            rom_loaded <= (state_n == LOAD) ? 1'b0 : ((state == HOLD && state_n == RUN) ? 1'b1 : rom_loaded);
            dl_error   <= (state != LOAD && state_n == LOAD) ? 1'b0
                          : dl_error | (rom_byte & ~in_range) | (push & ~push_ok);
            if (ioctl_wr && ioctl_index == DSW_INDEX && ioctl_addr[24:3] == '0)
                dsw[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
        end
    end
endmodule

// File: tb/tb_rom_dl_sequencer.sv
// tb_rom_dl_sequencer: directed self-checking bench for rom_dl_sequencer.
module tb_rom_dl_sequencer;
    import rom_dl_pkg::*;
    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download, ioctl_wr, rom_ready;
    logic [7:0]  ioctl_index, ioctl_dout;
    logic [24:0] ioctl_addr;
    logic        ioctl_wait, rom_wr, core_reset, rom_loaded, dl_error;
    logic [16:0] rom_addr;
    logic [7:0]  rom_data;
    logic [63:0] dsw;
    int vectors = 0;
    int errs = 0;

    rom_dl_sequencer dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_index    (ioctl_index),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .rom_wr         (rom_wr),
        .rom_ready      (rom_ready),
        .dsw            (dsw),
        .core_reset     (core_reset),
        .rom_loaded     (rom_loaded),
        .dl_error       (dl_error)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d);
        ioctl_wr   = 1'b1;
        ioctl_addr = a;
        ioctl_dout = d;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; rom_ready = 1'b1;
        ioctl_index = 8'd0; ioctl_addr = '0; ioctl_dout = '0;
        #3;
        chk("rst_rom_wr", rom_wr, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_data", rom_data, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_dsw", dsw, 0);
        chk("rst_core_reset", core_reset, 1);
        chk("rst_loaded", rom_loaded, 0);
        chk("rst_error", dl_error, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("idle_core_reset", core_reset, 1);

        // 16-byte load, target always ready
        ioctl_download = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) begin
            ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'(8'h30 + i);
            tick();
            chk("load_rom_wr", rom_wr, 1);
            chk("load_addr", rom_addr, i);
            chk("load_data", rom_data, 8'h30 + i);
            chk("load_wait", ioctl_wait, 0);
        end
        ioctl_wr = 1'b0; ioctl_download = 1'b0;
        tick();
        chk("last_pop_empty", rom_wr, 0);
        chk("drain_core_reset", core_reset, 1);
        repeat (16) tick();
        chk("hold_end_core_reset", core_reset, 1);
        chk("hold_end_loaded", rom_loaded, 0);
        tick();
        chk("run_core_reset", core_reset, 0);
        chk("run_loaded", rom_loaded, 1);
        chk("run_error", dl_error, 0);

        // DIP writes during RUN
        ioctl_index = 8'd254;
        strobe(25'd2, 8'hA5);
        strobe(25'd9, 8'h3C);
        chk("dsw_value", dsw, 64'h0000_0000_00A5_0000);
        chk("dsw_core_reset", core_reset, 0);
        chk("dsw_loaded", rom_loaded, 1);

        // Back-pressure with target stalled
        ioctl_index = 8'd0; rom_ready = 1'b0; ioctl_download = 1'b1;
        tick();
        chk("reload_core_reset", core_reset, 1);
        chk("reload_loaded", rom_loaded, 0);
        strobe(25'h100, 8'h50);
        chk("bp1_wait", ioctl_wait, 0);
        chk("bp1_head_addr", rom_addr, 17'h100);
        strobe(25'h101, 8'h51);
        chk("bp2_wait", ioctl_wait, 0);
        strobe(25'h102, 8'h52);
        chk("bp3_wait", ioctl_wait, 1);
        strobe(25'h103, 8'h53);
        chk("bp4_error", dl_error, 0);
        strobe(25'h104, 8'h54);
        chk("bp5_error", dl_error, 1);
        chk("bp5_head_addr", rom_addr, 17'h100);
        chk("bp5_head_data", rom_data, 8'h50);
        rom_ready = 1'b1;
        tick();
        chk("drain1_addr", rom_addr, 17'h101);
        chk("drain1_data", rom_data, 8'h51);
        tick();
        chk("drain2_addr", rom_addr, 17'h102);
        chk("drain2_data", rom_data, 8'h52);
        tick();
        chk("drain3_addr", rom_addr, 17'h103);
        chk("drain3_data", rom_data, 8'h53);
        tick();
        chk("drain4_empty", rom_wr, 0);
        chk("drain4_wait", ioctl_wait, 0);

        // Download falls with FIFO empty; restart during HOLD at counter 5
        ioctl_download = 1'b0;
        tick();
        chk("drain_state", dut.state, DRAIN);
        tick();
        chk("hold_state", dut.state, HOLD);
        repeat (10) tick();
        chk("hold_cnt", dut.cnt, 5);
        ioctl_download = 1'b1;
        tick();
        chk("restart_state", dut.state, LOAD);
        chk("restart_core_reset", core_reset, 1);
        chk("restart_error_clr", dl_error, 0);

        // Out-of-range byte, then top in-range address
        strobe(25'h20000, 8'h99);
        chk("oor_no_push", rom_wr, 0);
        chk("oor_error", dl_error, 1);
        strobe(25'h1FFFF, 8'h77);
        chk("edge_rom_wr", rom_wr, 1);
        chk("edge_addr", rom_addr, 17'h1FFFF);
        chk("edge_data", rom_data, 8'h77);
        ioctl_download = 1'b0;
        tick();
        chk("edge_popped", rom_wr, 0);
        repeat (16) tick();
        chk("rehold_core_reset", core_reset, 1);
        tick();
        chk("rehold_run", core_reset, 0);
        chk("rehold_loaded", rom_loaded, 1);
        chk("rehold_error_sticky", dl_error, 1);

        // Async reset with two bytes queued
        rom_ready = 1'b0; ioctl_download = 1'b1;
        tick();
        strobe(25'h10, 8'h01);
        strobe(25'h11, 8'h02);
        chk("prerst_rom_wr", rom_wr, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_rom_wr", rom_wr, 0);
        chk("arst_rom_addr", rom_addr, 0);
        chk("arst_core_reset", core_reset, 1);
        chk("arst_state", dut.state, IDLE);
        chk("arst_dsw", dsw, 0);
        chk("arst_error", dl_error, 0);
        ioctl_download = 1'b0; rom_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_rom_wr", rom_wr, 0);
        chk("post_rst_state", dut.state, IDLE);
        chk("post_rst_core_reset", core_reset, 1);
        chk("post_rst_loaded", rom_loaded, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
